mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory read latency in cycles from M_En assertion to valid M_Rdata; legal range 1..15.
REQ-002 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 IF_Req  in  1  instruction-fetch access request, level, held until IF_Ack.
REQ-005 IF_Addr  in  32  fetch byte address, stable while IF_Req is high.
REQ-006 IF_Rdata  out  32  registered fetch read data, valid from the IF_Ack cycle and held until the next fetch completes.
REQ-007 IF_Ack  out  1  one-cycle completion pulse for fetch.
REQ-008 D_Req  in  1  data access request, level, held until D_Ack.
REQ-009 D_WrEn  in  1  1 = store, 0 = load; stable while D_Req is high.
REQ-010 D_Addr  in  32  data byte address.
REQ-011 D_Wdata  in  32  store data.
REQ-012 D_Rdata  out  32  registered load data, valid from the D_Ack cycle and held until the next load completes.
REQ-013 D_Ack  out  1  one-cycle completion pulse for data.
REQ-014 M_En  out  1  memory access enable.
REQ-015 M_WrEn  out  1  memory write strobe.
REQ-016 M_Addr  out  32  registered memory address.
REQ-017 M_Wdata  out  32  registered memory write data.
REQ-018 M_Rdata  in  32  memory read data, valid MEM_LAT cycles after M_En first rises.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-020 In IDLE with any request, the FSM SHALL grant one requester and move to ACCESS at the next edge. At that edge it SHALL latch the granted address into M_Addr, D_Wdata into M_Wdata, D_WrEn, and the grant identity.
REQ-021 If only one request is high, that requester SHALL be granted.
REQ-022 If both requests are high, the requester not granted last SHALL win (round-robin). A 1-bit last_grant register SHALL update on every grant.
REQ-023 ACCESS SHALL last exactly MEM_LAT cycles, timed by a down-counter loaded with MEM_LAT-1. M_En SHALL be 1 throughout ACCESS.
REQ-024 M_WrEn SHALL be 1 only in the first ACCESS cycle, and only for a data store.
REQ-025 In the last ACCESS cycle (counter = 0), a read SHALL capture M_Rdata into the granted port's Rdata register. The FSM SHALL then move to RESP.
REQ-026 In RESP, the granted port's Ack SHALL be 1 for exactly one cycle. The FSM SHALL then return to IDLE.
REQ-027 Latency SHALL be MEM_LAT+1 cycles from the first ACCESS cycle to the Ack cycle. Back-to-back accesses SHALL therefore take MEM_LAT+2 cycles each, including the IDLE cycle.
REQ-028 Requests SHALL be sampled only in IDLE. A Req still high in the IDLE cycle after its Ack SHALL be treated as a new request.
REQ-029 A Req dropped during ACCESS SHALL NOT abort the access. The access SHALL complete and Ack SHALL still pulse.
REQ-030 A store SHALL leave D_Rdata unchanged, and a fetch SHALL leave D_Rdata unchanged. IF_Rdata SHALL change only on fetch completion.
REQ-031 IF_Ack and D_Ack SHALL never be high in the same cycle. M_En SHALL be 0 in IDLE and RESP.

Reset
REQ-032 Reset, whether asserted in IDLE or mid-operation, SHALL on the next edge:
- force the state to IDLE;
- set last_grant = IF, so the first tie goes to data;
- zero the counter, M_En, M_WrEn, M_Addr, M_Wdata, IF_Ack, D_Ack, IF_Rdata and D_Rdata.
REQ-033 An access interrupted by Reset SHALL produce no Ack and no further M_WrEn.

Verification
REQ-034 MEM_LAT=2, single fetch with IF_Addr=0x00000010 and M_Rdata=0x8C220004 -> M_En high for 2 cycles, IF_Ack on the 3rd cycle after grant, IF_Rdata=0x8C220004.
REQ-035 Store with D_Addr=0x40 and D_Wdata=0xDEADBEEF -> M_WrEn high for one cycle with M_Addr=0x40 and M_Wdata=0xDEADBEEF, then D_Ack; D_Rdata stays 0.
REQ-036 After reset, IF_Req and D_Req rise together and are held through four accesses -> grants go D, IF, D, IF; Acks are spaced MEM_LAT+2 cycles apart and never overlap.
REQ-037 Reset asserted in the 2nd ACCESS cycle of a load -> next edge IDLE with all outputs 0, and no D_Ack.
REQ-038 MEM_LAT=1, load with M_Rdata=0x12345678 -> one M_En cycle, D_Ack the next cycle, D_Rdata=0x12345678.
REQ-039 D_Req dropped in the 1st ACCESS cycle -> access completes and D_Ack still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter onto one fixed-latency memory port
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  output logic [31:0] IF_Rdata,
  output logic        IF_Ack,
  input  logic        D_Req,
  input  logic        D_WrEn,
  input  logic [31:0] D_Addr,
  input  logic [31:0] D_Wdata,
  output logic [31:0] D_Rdata,
  output logic        D_Ack,
  output logic        M_En,
  output logic        M_WrEn,
  output logic [31:0] M_Addr,
  output logic [31:0] M_Wdata,
  input  logic [31:0] M_Rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Counter reload: ACCESS lasts MEM_LAT cycles, counting MEM_LAT-1 down to 0.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       last_grant;  // 0 = fetch won last, 1 = data won last
  logic       grant_d;     // owner of the access in flight
  logic       wr_q;        // access in flight is a data store
  logic       pick_d;      // arbitration result if granting this cycle
  logic       any_req;

  // Arbitration, next state and the strobes decoded from the current state.
  always_comb begin
    state_nxt = state;
    M_En      = 1'b0;
    M_WrEn    = 1'b0;
    IF_Ack    = 1'b0;
    D_Ack     = 1'b0;
    any_req   = IF_Req | D_Req;
    // Data wins when alone, or on a tie when fetch was granted last.
    pick_d    = D_Req & (~IF_Req | ~last_grant);
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        M_En   = 1'b1;
        // The write strobe is only raised on the first access cycle.
        M_WrEn = wr_q & (cnt == CNT_LOAD);
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        IF_Ack    = ~grant_d;
        D_Ack     = grant_d;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant capture, latency counter and read-data return registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt        <= 4'd0;
      last_grant <= 1'b0;
      grant_d    <= 1'b0;
      wr_q       <= 1'b0;
      M_Addr     <= 32'd0;
      M_Wdata    <= 32'd0;
      IF_Rdata   <= 32'd0;
      D_Rdata    <= 32'd0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_d    <= pick_d;
        last_grant <= pick_d;
        wr_q       <= pick_d & D_WrEn;
        M_Addr     <= pick_d ? D_Addr : IF_Addr;
        M_Wdata    <= D_Wdata;
        cnt        <= CNT_LOAD;
      end else if (state == ACCESS) begin
        if (cnt == 4'd0) begin
          // Stores return nothing; reads land only in the owner's register.
          if (!wr_q) begin
            if (grant_d) begin
              D_Rdata <= M_Rdata;
            end else begin
              IF_Rdata <= M_Rdata;
            end
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule
